// File: rtl/sumres_pkg.sv
// sumres_pkg: shared constants for the sumador_restador absolute-difference unit.
//   SUMRES_WIDTH_DEF : default operand/result width.
//   SUMRES_MAX_WIDTH : widest supported operand/result width.
//   SUMRES_ZERO      : all-zero reset value, sliced to the instance width.
package sumres_pkg;

  localparam int SUMRES_WIDTH_DEF = 4;
  localparam int SUMRES_MAX_WIDTH = 16;

  localparam logic [SUMRES_MAX_WIDTH-1:0] SUMRES_ZERO = 16'h0000;

endpackage

// File: rtl/sumador_restador_if.sv
// sumador_restador_if: operand/result bundle for the absolute-difference unit.
//   in_valid, a, b : operand pair, driven by the master.
//   s, out_valid   : registered |a - b| and its valid flag, driven by the slave.
//   b_gt_a         : registered sign flag (only when SUMRES_SIGN_EN is defined).
// Modports: master (producer of operands), slave (the unit itself).
interface sumador_restador_if
  import sumres_pkg::*;
#(
  parameter int WIDTH = SUMRES_WIDTH_DEF
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             out_valid;
`ifdef SUMRES_SIGN_EN
  logic             b_gt_a;

  modport master (output in_valid, output a, output b,
                  input  s, input out_valid, input b_gt_a);
  modport slave  (input  in_valid, input a, input b,
                  output s, output out_valid, output b_gt_a);
`else
  modport master (output in_valid, output a, output b,
                  input  s, input out_valid);
  modport slave  (input  in_valid, input a, input b,
                  output s, output out_valid);
`endif

endinterface

// File: rtl/sumador_restador_full_adder.sv
// full_adder: 1-bit full adder cell used to build the a + ~b + 1 ripple chain.
//   x, y : addend bits
//   ci   : carry in
//   sum  : sum bit
//   co   : carry out
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/sumador_restador.sv
// sumador_restador: registered unsigned absolute difference s = |a - b|.
//   clk  : system clock, rising-edge state updates
//   rst  : synchronous, active-high reset (priority over in_valid)
//   bus  : sumador_restador_if.slave (in_valid, a, b -> s, out_valid[, b_gt_a])
// Optional feature macro SUMRES_SIGN_EN adds the registered b_gt_a flag.
// Result appears one cycle after the accepting edge; throughput one pair/cycle.
module sumador_restador
  import sumres_pkg::*;
#(
  parameter int WIDTH = SUMRES_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  sumador_restador_if.slave   bus
);

  logic [WIDTH-1:0] nb_s;      // ~b, so the chain computes a + ~b + 1
  logic [WIDTH:0]   c_s;       // ripple carries of the subtract chain
  logic [WIDTH-1:0] d_s;       // low WIDTH bits of a - b
  logic             carry_s;   // 1 when a >= b
  logic [WIDTH:0]   hc_s;      // ripple carries of the negate increment
  logic [WIDTH-1:0] neg_s;     // (~d) + 1, i.e. b - a when a < b
  logic [WIDTH-1:0] result_s;

  logic [WIDTH-1:0] s_r;
  logic             out_valid_r;
`ifdef SUMRES_SIGN_EN
  logic             b_gt_a_r;
`endif

  assign nb_s    = ~bus.b;
  assign c_s[0]  = 1'b1;
  assign carry_s = c_s[WIDTH];

  // Two's-complement subtract a - b as a ripple of full adders with carry-in 1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_sub
    full_adder u_fa (
      .x   (bus.a[i]),
      .y   (nb_s[i]),
      .ci  (c_s[i]),
      .sum (d_s[i]),
      .co  (c_s[i+1])
    );
  end

  // Increment ~d by one with half-adder cells: bit toggles while carry propagates.
  assign hc_s[0] = 1'b1;
  for (genvar j = 0; j < WIDTH; j++) begin : g_neg
    assign neg_s[j]  = (~d_s[j]) ^ hc_s[j];
    assign hc_s[j+1] = (~d_s[j]) & hc_s[j];
  end

  // Pick the non-negative form of the difference.
  always_comb begin
    result_s = d_s;
    if (carry_s) begin
      result_s = d_s;
    end else begin
      result_s = neg_s;
    end
  end

  // Output registers: reset first, capture on in_valid, otherwise hold s and drop valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r         <= SUMRES_ZERO[WIDTH-1:0];
      out_valid_r <= 1'b0;
`ifdef SUMRES_SIGN_EN
      b_gt_a_r    <= 1'b0;
`endif
    end else if (bus.in_valid) begin
      s_r         <= result_s;
      out_valid_r <= 1'b1;
`ifdef SUMRES_SIGN_EN
      b_gt_a_r    <= ~carry_s;
`endif
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.s         = s_r;
  assign bus.out_valid = out_valid_r;
`ifdef SUMRES_SIGN_EN
  assign bus.b_gt_a    = b_gt_a_r;
`endif

endmodule

// File: tb/tb_sumador_restador.sv
// tb_sumador_restador: directed self-checking bench for sumador_restador (WIDTH = 4).
// Inputs change on the falling edge; outputs are sampled 1 time unit after the
// rising edge that accepted the operands. b_gt_a is checked only when
// SUMRES_SIGN_EN is defined.
module tb_sumador_restador;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sumador_restador_if #(.WIDTH(4)) bus ();

  sumador_restador #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one pair (or idle) on the falling edge, then sample after the next rising edge.
  task automatic cycle(input logic v, input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] es, input logic ev,
                            input logic eg);
    check({tag, ".s"}, {12'h000, bus.s}, {12'h000, es});
    check({tag, ".out_valid"}, {15'h0000, bus.out_valid}, {15'h0000, ev});
`ifdef SUMRES_SIGN_EN
    check({tag, ".b_gt_a"}, {15'h0000, bus.b_gt_a}, {15'h0000, eg});
`else
    if (eg === 1'bx) $display("unexpected unknown sign expectation");
`endif
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 4'd5;
    bus.b        = 4'd3;

    // Reset held for two edges with a valid pair present: pair must be discarded.
    cycle(1'b1, 4'd5, 4'd3);
    expect_out("reset0", 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 4'd5, 4'd3);
    expect_out("reset1", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Directed vectors with hand-computed results.
    cycle(1'b1, 4'd12, 4'd5);  expect_out("a12_b5",  4'd7,  1'b1, 1'b0);
    cycle(1'b1, 4'd15, 4'd0);  expect_out("a15_b0",  4'd15, 1'b1, 1'b0);
    cycle(1'b1, 4'd4,  4'd5);  expect_out("a4_b5",   4'd1,  1'b1, 1'b1);
    cycle(1'b1, 4'd1,  4'd8);  expect_out("a1_b8",   4'd7,  1'b1, 1'b1);
    cycle(1'b1, 4'd0,  4'd8);  expect_out("a0_b8",   4'd8,  1'b1, 1'b1);
    cycle(1'b1, 4'd15, 4'd15); expect_out("a15_b15", 4'd0,  1'b1, 1'b0);
    cycle(1'b1, 4'd0,  4'd15); expect_out("a0_b15",  4'd15, 1'b1, 1'b1);

    // Every pair back to back, one per cycle.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        cycle(1'b1, 4'(ia), 4'(ib));
        expect_out($sformatf("exh_a%0d_b%0d", ia, ib),
                   (ia >= ib) ? 4'(ia - ib) : 4'(ib - ia), 1'b1, (ib > ia) ? 1'b1 : 1'b0);
      end
    end

    // Hold: in_valid drops, s keeps 4 even though a/b change.
    cycle(1'b1, 4'd6, 4'd2);  expect_out("hold_load", 4'd4, 1'b1, 1'b0);
    cycle(1'b0, 4'd9, 4'd1);  expect_out("hold1",     4'd4, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 4'd15); expect_out("hold2",     4'd4, 1'b0, 1'b0);

    // Mid-stream reset pulse clears s, then the next pair lands one cycle later.
    rst = 1'b1;
    cycle(1'b0, 4'd0, 4'd0);  expect_out("midrst",    4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cycle(1'b1, 4'd3, 4'd9);  expect_out("after_rst", 4'd6, 1'b1, 1'b1);
    cycle(1'b0, 4'd3, 4'd9);  expect_out("idle_end",  4'd6, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
